voq_buffer: RTL and testbench
=============================

Name: voq_buffer

Overview:
- Multi-queue packet-word buffer for the switch datapath.
- Holds NUM_QUEUES independent circular FIFOs, one per virtual output queue, statically partitioned inside a single dual-port memory.
- Port A is the enqueue (write) side, fed by ingress; port B is the dequeue (read) side, driven by the scheduler.
- Generalises the plain dual-port RAM with queue addressing, pointer management, occupancy tracking and overflow/underflow protection.

Parameters:
- DATA_WIDTH, 32, bits per stored word.
- NUM_QUEUES, 4, number of queues; power of 2, >=2.
- QUEUE_DEPTH, 128, words per queue; power of 2, >=2.
- Derived, not overridable:
  - QW = $clog2(NUM_QUEUES)
  - PW = $clog2(QUEUE_DEPTH)
  - CW = $clog2(QUEUE_DEPTH+1)

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- enq_valid  in  1  enqueue request.
- enq_queue  in  QW  target queue.
- enq_data  in  DATA_WIDTH  word to store.
- enq_ready  out  1  combinational: !q_full[enq_queue].
- deq_req  in  1  dequeue request.
- deq_queue  in  QW  source queue.
- deq_valid  out  1  deq_data/deq_tag valid this cycle.
- deq_data  out  DATA_WIDTH  dequeued word.
- deq_tag  out  QW  queue that deq_data came from.
- q_empty  out  NUM_QUEUES  per-queue empty, registered.
- q_full  out  NUM_QUEUES  per-queue full, registered.
- q_count  out  NUM_QUEUES*CW  per-queue occupancy; queue q at bits [q*CW +: CW].
- enq_drop  out  1  one-cycle pulse: a rejected enqueue occurred the previous cycle.
- deq_underflow  out  1  one-cycle pulse: a rejected dequeue occurred the previous cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Storage: NUM_QUEUES*QUEUE_DEPTH words. Queue q owns addresses q*QUEUE_DEPTH .. q*QUEUE_DEPTH+QUEUE_DEPTH-1.
  - Physical address = {queue, pointer}. No sharing between queues.
- Per-queue state: head (PW bits), tail (PW bits), count (CW bits).
  - Pointers wrap modulo QUEUE_DEPTH naturally.
  - q_empty[q] = (count==0); q_full[q] = (count==QUEUE_DEPTH). Both are derived from the registered count.
- Reset values:
  - All head/tail/count = 0; q_empty all 1; q_full all 0; q_count 0.
  - deq_valid 0, deq_data 0, deq_tag 0, enq_drop 0, deq_underflow 0.
  - Memory contents are not cleared.
- Enqueue: accepted in cycle t iff enq_valid && !q_full[enq_queue].
  - Write enq_data at {enq_queue, tail}.
  - tail+1 and count+1 take effect at t+1.
  - Rejected enqueue: no state change; enq_drop=1 at t+1.
- Dequeue: accepted in cycle t iff deq_req && !q_empty[deq_queue].
  - Read {deq_queue, head}.
  - At t+1: deq_valid=1, deq_data=word, deq_tag=deq_queue; head+1 and count-1 take effect.
  - Latency is 1 cycle.
  - Rejected dequeue: deq_valid=0 at t+1, deq_underflow=1 at t+1.
- deq_data and deq_tag hold their last values while deq_valid=0.
- Acceptance uses only registered state; there is no bypass.
  - An enqueue into an empty queue is dequeuable no earlier than the next cycle.
  - An enqueue into a full queue is rejected even if the same queue is dequeued in the same cycle.
- Simultaneous accepted enqueue and dequeue:
  - Same queue: count unchanged; head and tail both advance.
  - Different queues: each queue updates independently.
- No read-during-write hazard: an accepted dequeue always reads an entry written in an earlier cycle.
- enq_drop and deq_underflow may both pulse in the same cycle.
- Reset asserted mid-operation: any in-flight dequeue is discarded. deq_valid=0 in the cycle after reset is sampled, and all queues read empty.
- Throughput: one enqueue plus one dequeue per cycle, sustained, with no bubbles.

Test Plan:
1. Reset, then enqueue 0xA0..0xA3 into q2 on consecutive cycles, then dequeue q2 x4 back-to-back → deq_data 0xA0,0xA1,0xA2,0xA3, each one cycle after its request; deq_tag=2; q_empty[2]=1 at end.
2. Fill q1 with QUEUE_DEPTH words → q_full[1]=1, enq_ready=0 for q1. One more enqueue → enq_drop pulses for one cycle, q_count[1] stays 128. Then dequeue one and enqueue one → count returns to 128 and FIFO order is preserved.
3. Wrap: enqueue/dequeue q0 continuously for 3*QUEUE_DEPTH words with a running pattern → every dequeued word equals its enqueue order; count never exceeds 1.
4. Same-cycle enqueue and dequeue on q3 holding 5 words → q_count[3] stays 5. Enqueue to an empty q0 plus dequeue of q0 in the same cycle → dequeue rejected, deq_underflow=1, q_count[0]=1.
5. Interleave q0..q3 with tagged data (queue<<8 | seq) → every queue returns its own sequence in order; no cross-queue corruption.
6. Assert reset while a dequeue is in flight, with q1 holding 3 words → deq_valid=0 next cycle; q_empty=all 1 and q_count=0 after reset.

Source files
------------

// File: rtl/voq_buffer.sv
// Multi-queue word buffer: NUM_QUEUES circular FIFOs statically partitioned in one dual-port memory.
// Latency: enqueue visible to dequeue next cycle; dequeue data appears 1 cycle after an accepted request.
// Backpressure: enq_ready drops when the target queue is full; rejected enq/deq pulse enq_drop/deq_underflow.
module voq_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_QUEUES  = 4,
   parameter int QUEUE_DEPTH = 128,
   localparam int QW = $clog2(NUM_QUEUES),
   localparam int PW = $clog2(QUEUE_DEPTH),
   localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq_valid,
   input  logic [QW-1:0]            enq_queue,
   input  logic [DATA_WIDTH-1:0]    enq_data,
   output logic                     enq_ready,
   input  logic                     deq_req,
   input  logic [QW-1:0]            deq_queue,
   output logic                     deq_valid,
   output logic [DATA_WIDTH-1:0]    deq_data,
   output logic [QW-1:0]            deq_tag,
   output logic [NUM_QUEUES-1:0]    q_empty,
   output logic [NUM_QUEUES-1:0]    q_full,
   output logic [NUM_QUEUES*CW-1:0] q_count,
   output logic                     enq_drop,
   output logic                     deq_underflow
);

   localparam int AW = QW + PW;

   logic [DATA_WIDTH-1:0] mem [NUM_QUEUES*QUEUE_DEPTH];
   logic [PW-1:0]         head  [NUM_QUEUES];
   logic [PW-1:0]         tail  [NUM_QUEUES];
   logic [CW-1:0]         count [NUM_QUEUES];

   logic          enq_acc;
   logic          deq_acc;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   // Acceptance looks only at registered occupancy, so a full queue stays closed
   // even when it is dequeued in the same cycle, and an empty queue cannot be
   // read in the cycle it is written. This also rules out read/write collisions.
   assign enq_ready = !q_full[enq_queue];
   assign enq_acc   = enq_valid && enq_ready;
   assign deq_acc   = deq_req && !q_empty[deq_queue];
   assign wr_addr   = {enq_queue, tail[enq_queue]};
   assign rd_addr   = {deq_queue, head[deq_queue]};

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_status
      assign q_empty[g]            = (count[g] == '0);
      assign q_full[g]             = (count[g] == CW'(QUEUE_DEPTH));
      assign q_count[g*CW +: CW]   = count[g];
   end

   // Write port: storage is never cleared, so it carries no reset.
   always_ff @(posedge clk) begin
      if (enq_acc) begin
         mem[wr_addr] <= enq_data;
      end
   end

   // Read port and status pulses; data and tag hold while no dequeue completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         deq_valid     <= 1'b0;
         deq_data      <= '0;
         deq_tag       <= '0;
         enq_drop      <= 1'b0;
         deq_underflow <= 1'b0;
      end else begin
         deq_valid     <= deq_acc;
         enq_drop      <= enq_valid && !enq_acc;
         deq_underflow <= deq_req && !deq_acc;
         if (deq_acc) begin
            deq_data <= mem[rd_addr];
            deq_tag  <= deq_queue;
         end
      end
   end

   // Per-queue pointer and occupancy update; same-queue enq+deq leaves count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            head[q]  <= '0;
            tail[q]  <= '0;
            count[q] <= '0;
         end
      end else begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            if (enq_acc && (enq_queue == QW'(q))) begin
               tail[q] <= tail[q] + PW'(1);
            end
            if (deq_acc && (deq_queue == QW'(q))) begin
               head[q] <= head[q] + PW'(1);
            end
            if ((enq_acc && (enq_queue == QW'(q))) && !(deq_acc && (deq_queue == QW'(q)))) begin
               count[q] <= count[q] + CW'(1);
            end else if (!(enq_acc && (enq_queue == QW'(q))) && (deq_acc && (deq_queue == QW'(q)))) begin
               count[q] <= count[q] - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_voq_buffer.sv
// Self-checking bench for voq_buffer against a per-queue list model.
// Latency: every cycle's outputs are checked 1 time unit after the edge.
// Backpressure: full/empty rejections are predicted from model queue sizes.
module tb_voq_buffer;

   localparam int DW    = 32;
   localparam int NQ    = 4;
   localparam int DEPTH = 128;
   localparam int QW    = $clog2(NQ);
   localparam int CW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enq_valid = 1'b0;
   logic [QW-1:0]     enq_queue = '0;
   logic [DW-1:0]     enq_data = '0;
   logic              enq_ready;
   logic              deq_req = 1'b0;
   logic [QW-1:0]     deq_queue = '0;
   logic              deq_valid;
   logic [DW-1:0]     deq_data;
   logic [QW-1:0]     deq_tag;
   logic [NQ-1:0]     q_empty;
   logic [NQ-1:0]     q_full;
   logic [NQ*CW-1:0]  q_count;
   logic              enq_drop;
   logic              deq_underflow;

   voq_buffer #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ), .QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_queue(enq_queue), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_req(deq_req), .deq_queue(deq_queue),
      .deq_valid(deq_valid), .deq_data(deq_data), .deq_tag(deq_tag),
      .q_empty(q_empty), .q_full(q_full), .q_count(q_count),
      .enq_drop(enq_drop), .deq_underflow(deq_underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one list of words per queue, plus the last word handed out.
   logic [DW-1:0] mq [NQ][$];
   logic [DW-1:0] last_data = '0;
   int            last_tag  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, predict from model sizes, clock, update model, compare.
   task automatic cyc(input bit rst, input bit ev, input int eq, input logic [DW-1:0] ed,
                      input bit dr, input int dq);
      bit e_acc, d_acc, exp_drop, exp_uf, exp_valid;
      logic [NQ*CW-1:0] exp_cnt;
      logic [NQ-1:0]    exp_empty, exp_full;
      reset     = rst;
      enq_valid = ev;
      enq_queue = QW'(eq);
      enq_data  = ed;
      deq_req   = dr;
      deq_queue = QW'(dq);
      #1;
      if (!rst) chk("enq_ready", 64'(enq_ready), 64'(mq[eq].size() != DEPTH));
      e_acc    = ev && (mq[eq].size() < DEPTH);
      d_acc    = dr && (mq[dq].size() > 0);
      exp_drop = ev && !e_acc;
      exp_uf   = dr && !d_acc;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int q = 0; q < NQ; q++) mq[q].delete();
         last_data = '0;
         last_tag  = 0;
         exp_valid = 0;
         exp_drop  = 0;
         exp_uf    = 0;
      end else begin
         exp_valid = d_acc;
         if (d_acc) begin
            last_data = mq[dq].pop_front();
            last_tag  = dq;
         end
         if (e_acc) mq[eq].push_back(ed);
      end
      for (int q = 0; q < NQ; q++) begin
         exp_cnt[q*CW +: CW] = CW'(mq[q].size());
         exp_empty[q]        = (mq[q].size() == 0);
         exp_full[q]         = (mq[q].size() == DEPTH);
      end
      chk("deq_valid",     64'(deq_valid),     64'(exp_valid));
      chk("deq_data",      64'(deq_data),      64'(last_data));
      chk("deq_tag",       64'(deq_tag),       64'(last_tag));
      chk("enq_drop",      64'(enq_drop),      64'(exp_drop));
      chk("deq_underflow", 64'(deq_underflow), 64'(exp_uf));
      chk("q_count",       64'(q_count),       64'(exp_cnt));
      chk("q_empty",       64'(q_empty),       64'(exp_empty));
      chk("q_full",        64'(q_full),        64'(exp_full));
   endtask

   task automatic idle();
      cyc(0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      // Reset state
      cyc(1, 0, 0, '0, 0, 0);
      chk("reset_empty", 64'(q_empty), 64'({NQ{1'b1}}));
      chk("reset_count", 64'(q_count), 64'(0));

      // 1: ordered enqueue then back-to-back dequeue on q2
      for (int i = 0; i < 4; i++) cyc(0, 1, 2, DW'(32'hA0 + i), 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, '0, 1, 2);
         chk("t1_data", 64'(deq_data), 64'(32'hA0 + i));
      end
      chk("t1_tag", 64'(deq_tag), 64'(2));
      chk("t1_empty2", 64'(q_empty[2]), 64'(1));

      // 2: fill q1, overflow once, then dequeue one and enqueue one
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, DW'(32'h1000 + i), 0, 0);
      chk("t2_full1", 64'(q_full[1]), 64'(1));
      cyc(0, 1, 1, DW'(32'hDEAD), 0, 0);
      chk("t2_drop", 64'(enq_drop), 64'(1));
      chk("t2_cnt", 64'(q_count[1*CW +: CW]), 64'(DEPTH));
      idle();
      chk("t2_drop_pulse", 64'(enq_drop), 64'(0));
      cyc(0, 1, 1, DW'(32'hBEEF), 1, 1);   // full queue rejects even with same-cycle dequeue
      chk("t2_first_out", 64'(deq_data), 64'(32'h1000));
      cyc(0, 1, 1, DW'(32'hBEEF), 0, 0);
      chk("t2_cnt_back", 64'(q_count[1*CW +: CW]), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, '0, 1, 1);
      chk("t2_last_out", 64'(deq_data), 64'(32'hBEEF));

      // 3: streaming through q0 for three full wraps
      cyc(0, 1, 0, DW'(32'h3000), 0, 0);
      for (int i = 1; i < 3*DEPTH; i++) begin
         cyc(0, 1, 0, DW'(32'h3000 + i), 1, 0);
         chk("t3_order", 64'(deq_data), 64'(32'h3000 + i - 1));
         chk("t3_cnt", 64'(q_count[0 +: CW]), 64'(1));
      end
      cyc(0, 0, 0, '0, 1, 0);

      // 4: simultaneous enq/deq on q3 at 5 words; enq+deq on empty q0
      for (int i = 0; i < 5; i++) cyc(0, 1, 3, DW'(32'h300 + i), 0, 0);
      cyc(0, 1, 3, DW'(32'h305), 1, 3);
      chk("t4_cnt3", 64'(q_count[3*CW +: CW]), 64'(5));
      cyc(0, 1, 0, DW'(32'h77), 1, 0);
      chk("t4_uf", 64'(deq_underflow), 64'(1));
      chk("t4_cnt0", 64'(q_count[0 +: CW]), 64'(1));
      cyc(1, 0, 0, '0, 0, 0);

      // 5: interleaved tagged traffic across all queues
      for (int s = 0; s < 6; s++)
         for (int q = 0; q < NQ; q++) cyc(0, 1, q, DW'((q << 8) | s), 1, (q + 1) % NQ);
      for (int q = 0; q < NQ; q++)
         while (mq[q].size() > 0) cyc(0, 0, 0, '0, 1, q);

      // 6: reset with a dequeue in flight on q1
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, DW'(32'h600 + i), 0, 0);
      cyc(1, 0, 0, '0, 1, 1);
      chk("t6_valid", 64'(deq_valid), 64'(0));
      chk("t6_empty", 64'(q_empty), 64'({NQ{1'b1}}));
      chk("t6_count", 64'(q_count), 64'(0));
      idle();

      // Randomised traffic: enqueue-heavy on q0/q1 to reach full, then drain-heavy
      for (int i = 0; i < 900; i++)
         cyc(0, ($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom,
             ($urandom_range(0, 9) < 3), $urandom_range(0, NQ - 1));
      for (int i = 0; i < 900; i++)
         cyc(0, ($urandom_range(0, 9) < 3), $urandom_range(0, NQ - 1), $urandom,
             ($urandom_range(0, 9) < 8), $urandom_range(0, NQ - 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
